// File: rtl/tcdm_bank_responder.sv
// TCDM memory bank endpoint: req/gnt request port, register-array storage and a
// credit-limited fall-through response FIFO on a valid/ready response port.
module tcdm_bank_responder #(
   parameter int unsigned NumWords     = 256,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned IdxWidth     = 10,
   parameter int unsigned RespDepth    = 2,
   parameter bit          WriteRespOn  = 1'b0,
   parameter int unsigned AddrMemWidth = $clog2(NumWords)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [AddrMemWidth-1:0] addr_i,
   input  logic                    wen_i,
   input  logic [DataWidth-1:0]    wdata_i,
   input  logic [DataWidth/8-1:0]  be_i,
   input  logic [IdxWidth-1:0]     idx_i,
   output logic                    vld_o,
   input  logic                    rdy_i,
   output logic [IdxWidth-1:0]     idx_o,
   output logic [DataWidth-1:0]    rdata_o
);

   localparam int unsigned BeWidth  = DataWidth / 8;
   localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
   localparam int unsigned CntWidth = $clog2(RespDepth + 1);
   localparam int unsigned InfWidth = CntWidth + 1;

   if (DataWidth % 8 != 0) begin : g_chk_data_width
      $error("DataWidth must be a multiple of 8");
   end
   if (RespDepth < 1) begin : g_chk_resp_depth
      $error("RespDepth must be at least 1");
   end
   if ((1 << AddrMemWidth) != NumWords) begin : g_chk_num_words
      $error("NumWords must be a power of two");
   end

   logic [DataWidth-1:0] r_mem      [NumWords];
   logic [IdxWidth-1:0]  r_fifo_idx [RespDepth];
   logic [DataWidth-1:0] r_fifo_data[RespDepth];

   logic                 r_s1_vld;
   logic [IdxWidth-1:0]  r_s1_idx;
   logic [DataWidth-1:0] r_s1_data;
   logic [PtrWidth-1:0]  r_wptr;
   logic [PtrWidth-1:0]  r_rptr;
   logic [CntWidth-1:0]  r_count;

   logic                 w_fifo_empty;
   logic                 w_fifo_full;
   logic [InfWidth-1:0]  w_inflight;
   logic                 w_needs_credit;
   logic                 w_gnt;
   logic                 w_s1_load;
   logic                 w_s1_bypass;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_vld;
   logic [IdxWidth-1:0]  w_idx;
   logic [DataWidth-1:0] w_rdata;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(RespDepth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   // Credit accounting is conservative: a pop in this cycle does not free a slot yet.
   assign w_fifo_empty   = (r_count == '0);
   assign w_fifo_full    = (r_count == CntWidth'(RespDepth));
   assign w_inflight     = {1'b0, r_count} + InfWidth'(r_s1_vld);
   assign w_needs_credit = ~wen_i | WriteRespOn;
   assign w_gnt          = req_i & ~rst_i & (~w_needs_credit | (w_inflight < InfWidth'(RespDepth)));
   assign w_s1_load      = w_gnt & w_needs_credit;
   assign gnt_o          = w_gnt;

   assign w_s1_bypass = w_fifo_empty & r_s1_vld & rdy_i;
   assign w_push      = r_s1_vld & ~w_s1_bypass;
   assign w_pop       = ~w_fifo_empty & rdy_i & ~rst_i;

   // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_vld   = 1'b0;
      w_idx   = '0;
      w_rdata = '0;
      if (!rst_i) begin
         if (!w_fifo_empty) begin
            w_vld   = 1'b1;
            w_idx   = r_fifo_idx[r_rptr];
            w_rdata = r_fifo_data[r_rptr];
         end else if (r_s1_vld) begin
            w_vld   = 1'b1;
            w_idx   = r_s1_idx;
            w_rdata = r_s1_data;
         end
      end
   end

   assign vld_o   = w_vld;
   assign idx_o   = w_idx;
   assign rdata_o = w_rdata;

   // NOTE: storage arrays carry no reset; only the valid/pointer state that qualifies them does.
   always_ff @(posedge clk_i) begin
      if (w_gnt && wen_i) begin
         for (int b = 0; b < BeWidth; b++) begin
            if (be_i[b]) r_mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
      if (w_push) begin
         r_fifo_idx[r_wptr]  <= r_s1_idx;
         r_fifo_data[r_wptr] <= r_s1_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1_vld  <= 1'b0;
         r_s1_idx  <= '0;
         r_s1_data <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
      end else begin
         r_s1_vld <= w_s1_load;
         if (w_s1_load) begin
            r_s1_idx  <= idx_i;
            r_s1_data <= wen_i ? '0 : r_mem[addr_i];
         end
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntWidth'(1);
            2'b01:   r_count <= r_count - CntWidth'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // The credit rule keeps s1 empty whenever the FIFO is full.
   a_no_full_and_s1 : assert property (@(posedge clk_i) disable iff (rst_i) !(w_fifo_full && r_s1_vld));

endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- Target-side endpoint of the TCDM interconnect: one memory bank that serves the requests the interconnect issues to its bank ports.
- Accepts req/gnt requests carrying a return index and returns read responses tagged with that index.
- Responses leave through a valid/ready port backed by a small credit-limited response FIFO.
- Instantiated once per bank inside a tile; it replaces a bare SRAM, so the tile can apply backpressure on its response path.

Parameters:
- NumWords, 256, number of words in the bank.
- DataWidth, 32, word width in bits; must be a multiple of 8.
- IdxWidth, 10, width of the return index (the requesting core id).
- RespDepth, 2, response FIFO depth, which is also the in-flight credit limit; must be at least 1.
- WriteRespOn, 0, when 1, writes also produce a response.
- AddrMemWidth, $clog2(NumWords), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  AddrMemWidth  word address.
- wen_i  in  1  1 = write, 0 = read.
- wdata_i  in  DataWidth  write data.
- be_i  in  DataWidth/8  byte enables (write only).
- idx_i  in  IdxWidth  return index.
- vld_o  out  1  response valid.
- rdy_i  in  1  response consumer ready.
- idx_o  out  IdxWidth  response return index.
- rdata_o  out  DataWidth  response data.

Behaviour:
- Handshake
  - A request is accepted in the cycle where req_i and gnt_o are both high.
  - gnt_o is combinational from req_i and internal state, and is 0 whenever req_i = 0.
  - A response transfers in the cycle where vld_o and rdy_i are both high.
  - vld_o, idx_o and rdata_o are held stable until the response transfers.
- Memory
  - Register-array storage; contents are not reset.
  - A write accepted in cycle N updates only the bytes with be_i = 1, at the end of cycle N.
  - A read accepted in cycle N+1 to the same address returns the new data.
  - A write with be_i = 0 is granted and leaves memory unchanged.
- Read pipeline
  - A read accepted in cycle N samples the array in cycle N into stage s1 (valid, idx, data).
  - s1 presents its response in cycle N+1.
- Output path
  - The FIFO is fall-through: if the FIFO is empty, vld_o, idx_o and rdata_o come from s1.
  - If the FIFO is empty and s1 transfers in the same cycle, the s1 entry is consumed and is not pushed.
  - In all other cases a valid s1 entry is pushed into the FIFO, and the FIFO head drives the outputs.
  - Responses leave strictly in acceptance order.
  - Minimum read latency is 1 cycle.
- Credits
  - inflight = s1 valid (response-bearing) + FIFO count.
  - A read (or a write when WriteRespOn = 1) is granted only if inflight < RespDepth.
  - Credits freed by a pop in the same cycle are not counted; the grant decision is conservative.
  - When WriteRespOn = 0, writes are always granted and consume no credit.
  - With RespDepth >= 2 and rdy_i held at 1, back-to-back reads sustain one grant per cycle.
- Write responses (WriteRespOn = 1)
  - Returned through s1 and the FIFO like reads, with rdata_o = 0 and the same latency.
- Idle outputs
  - When vld_o = 0, idx_o and rdata_o are driven to 0.
- Reset
  - While rst_i = 1: gnt_o = 0, vld_o = 0, idx_o = 0, rdata_o = 0.
  - Reset clears s1 and the FIFO and drops any in-flight responses; memory contents are kept.
  - A request presented during reset is neither granted nor executed.
- Boundary conditions
  - FIFO full and s1 valid cannot both hold, by the credit rule; add an assertion for it.
  - Push and pop in the same cycle are both allowed when the FIFO is non-empty.
  - Address wrap does not occur: addr_i already indexes words 0..NumWords-1, and NumWords must be a power of two (elaboration check).

Test Plan:
- Write addr 5 = 0xDEADBEEF with be = 4'hF in cycle 0, then read addr 5 with idx 0x2A in cycle 1 -> vld_o in cycle 2 with rdata 0xDEADBEEF and idx 0x2A; the write produces no response.
- Write 0xFFFFFFFF to addr 7, then write 0x00000012 with be = 4'b0001, then read addr 7 -> rdata 0xFFFFFF12.
- With RespDepth = 2, rdy_i = 0, issue 4 reads continuously -> exactly 2 grants, vld_o held high on the first response. Then set rdy_i = 1 -> 2 responses in order, after which grants resume.
- With rdy_i = 1, issue 8 back-to-back reads of addr 0..7 -> one gnt per cycle and one response per cycle, in order, each 1 cycle after its acceptance.
- With WriteRespOn = 1, write addr 3 with idx 9 -> a response 1 cycle later with idx 9 and rdata 0, consuming one credit.
- Pend 2 responses with rdy_i = 0, then assert rst_i for 1 cycle -> vld_o = 0 and gnt_o = 0 during reset. After reset, vld_o stays 0, a read of previously written data returns it, and full credit is restored.
